// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and 7-segment encodings for the display scan driver
// Segment bit order is {g,f,e,d,c,b,a}, active-high before any output inversion.
package display_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

  localparam seg_t SEG_0    = 7'b0111111;
  localparam seg_t SEG_1    = 7'b0000110;
  localparam seg_t SEG_2    = 7'b1011011;
  localparam seg_t SEG_3    = 7'b1001111;
  localparam seg_t SEG_4    = 7'b1100110;
  localparam seg_t SEG_5    = 7'b1101101;
  localparam seg_t SEG_6    = 7'b1111101;
  localparam seg_t SEG_7    = 7'b0000111;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1101111;
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/display_scan_driver_if.sv
// rtl/display_scan_driver_if.sv - digit input and display output bundle for display_scan_driver
// master = digit producer / observer, slave = the scan driver itself.
interface display_scan_driver_if #(
  parameter int NUM_DIGITS = 3
);

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    bcd_load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_done;

  modport master (
    output bcd_in, bcd_load,
    input  seg, dp, anode, frame_done
  );

  modport slave (
    input  bcd_in, bcd_load,
    output seg, dp, anode, frame_done
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to 7-segment decoder
// Non-decimal codes 10-15 render as a dash so corrupt counter values are visible.
module bcd_to_7seg
  import display_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - double-buffered, round-robin multiplexed 7-segment scan driver
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits above digit 0).
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic                  clk,
  input logic                  reset,
  display_scan_driver_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]         BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam slot_state_t           ST_RESET   = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
  localparam seg_t                  SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_INV     = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_shadow;
  logic [DW-1:0]         r_active;
  logic                  r_pending;
  slot_state_t           r_state;
  seg_t                  r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_anode;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_frame_end;
  logic [PW-1:0]         w_presc_next;
  slot_state_t           w_state_next;
  bcd_t                  w_cur_digit;
  seg_t                  w_dec;
  seg_t                  w_seg_next;
  logic [NUM_DIGITS-1:0] w_anode_next;

  always_comb begin
    w_tick       = (r_presc == PRESC_LAST);
    w_frame_end  = w_tick && (r_idx == IDX_LAST);
    w_presc_next = w_tick ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_presc_next;
      if (w_tick) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Active only changes at a frame boundary; a load landing on that cycle bypasses the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.bcd_load) r_shadow <= bus.bcd_in;
      if (w_frame_end) begin
        r_pending <= 1'b0;
        if (bus.bcd_load)   r_active <= bus.bcd_in;
        else if (r_pending) r_active <= r_shadow;
      end else if (bus.bcd_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) w_cur_digit = r_active[4*i +: 4];
    end
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_cur_digit),
    .o_seg (w_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IW'(i) >= r_idx) && (r_active[4*i +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_state_next;
  end

  // State tracks the prescaler value it will hold next, so BLANK covers exactly the slot head.
  always_comb begin
    w_state_next = (w_presc_next < BLANK_END) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    w_anode_next = '0;
    w_seg_next   = SEG_OFF;
    if (r_state == ST_SHOW) begin
      w_anode_next = NUM_DIGITS'(1) << r_idx;
`ifdef LEADING_ZERO_BLANK_EN
      w_seg_next = ((r_idx != '0) && w_upper_zero) ? SEG_OFF : w_dec;
`else
      w_seg_next = w_dec;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode      <= AN_INV;
      r_seg        <= SEG_INV;
      r_dp         <= DP_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_anode      <= w_anode_next ^ AN_INV;
      r_seg        <= w_seg_next ^ SEG_INV;
      r_dp         <= DP_OFF;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.anode      = r_anode;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - directed self-checking bench for display_scan_driver
// PRESCALE=4, BLANK_CYCLES=1, NUM_DIGITS=3, active-high outputs; 12-cycle frames.
module tb_display_scan_driver;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  display_scan_driver_if #(.NUM_DIGITS(3)) bus ();

  display_scan_driver #(
    .NUM_DIGITS     (3),
    .PRESCALE       (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input logic [11:0] d, input int s);
    logic [3:0] v;
`ifdef LEADING_ZERO_BLANK_EN
    logic hz;
    hz = 1'b1;
    for (int j = s; j < 3; j++) if (d[4*j +: 4] != 4'd0) hz = 1'b0;
    if (s > 0 && hz) return 7'b0000000;
`endif
    v = d[4*s +: 4];
    return SEG_TAB[v];
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, " anode"}, 32'(bus.anode), 32'd0);
    check_val({tag, " seg"}, 32'(bus.seg), 32'd0);
    check_val({tag, " dp"}, 32'(bus.dp), 32'd0);
    check_val({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  // One full frame from slot 0 presc 0; optional loads applied on frame cycle la / lb.
  task automatic run_frame(input string tag, input logic [11:0] exp_d,
                           input int la, input logic [11:0] va,
                           input int lb, input logic [11:0] vb);
    int s;
    int p;
    logic [31:0] ex_an;
    logic [31:0] ex_seg;
    for (int j = 0; j < 12; j++) begin
      s = j / 4;
      p = j % 4;
      if (j == la) begin
        bus.bcd_in = va;
        bus.bcd_load = 1'b1;
      end else if (j == lb) begin
        bus.bcd_in = vb;
        bus.bcd_load = 1'b1;
      end
      step();
      bus.bcd_load = 1'b0;
      bus.bcd_in = 12'hEEE;
      ex_an  = (p >= 1) ? (32'd1 << s) : 32'd0;
      ex_seg = (p >= 1) ? 32'(exp_seg(exp_d, s)) : 32'd0;
      check_val($sformatf("%s anode s%0d p%0d", tag, s, p), 32'(bus.anode), ex_an);
      check_val($sformatf("%s seg s%0d p%0d", tag, s, p), 32'(bus.seg), ex_seg);
      check_val($sformatf("%s frame_done s%0d p%0d", tag, s, p), 32'(bus.frame_done),
                (j == 11) ? 32'd1 : 32'd0);
      check_val($sformatf("%s dp s%0d p%0d", tag, s, p), 32'(bus.dp), 32'd0);
    end
  endtask

  initial begin
    bus.bcd_in = '0;
    bus.bcd_load = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    check_reset_state("init_rst");
    reset = 1'b0;

    run_frame("f0", 12'h000, 5, 12'h072, -1, 12'h000);
    run_frame("f1", 12'h072, -1, 12'h000, -1, 12'h000);
    run_frame("f2", 12'h072, 5, 12'h123, -1, 12'h000);
    run_frame("f3", 12'h123, 11, 12'h456, -1, 12'h000);
    run_frame("f4", 12'h456, 2, 12'h999, 7, 12'h0C5);
    run_frame("f5", 12'h0C5, 3, 12'h005, -1, 12'h000);
    run_frame("f6", 12'h005, -1, 12'h000, -1, 12'h000);

    repeat (4) step();
    bus.bcd_in = 12'h777;
    bus.bcd_load = 1'b1;
    step();
    bus.bcd_load = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    check_reset_state("mid_rst");
    reset = 1'b0;

    run_frame("r0", 12'h000, -1, 12'h000, -1, 12'h000);
    run_frame("r1", 12'h000, -1, 12'h000, -1, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
